// File: rtl/bloco_controle_pkg.sv
// -----------------------------------------------------------------------------
// bloco_controle_pkg
// Shared definitions for the Horner control unit and the operative block:
//   - estado_t     : FSM state encoding (3-bit; codes 7 is unused)
//   - SEL0_*       : operand mux (M0) select values
//   - SEL1_*       : ALU port b mux (M1) select values
//   - SEL2_*       : ALU port a mux (M2) select values
//   - ALU_OP_*     : ALU operation select values (H)
// Optional feature macro used by the users of this package:
//   BLOCO_CONTROLE_CONTADOR_EN (completed-run counter output).
// -----------------------------------------------------------------------------
package bloco_controle_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARGA_X = 3'd1,
        MUL_A   = 3'd2,
        SOMA_B  = 3'd3,
        MUL_X   = 3'd4,
        SOMA_C  = 3'd5,
        FIM     = 3'd6
    } estado_t;

    // M0: operand mux
    localparam logic [1:0] SEL0_ZERO = 2'b00;
    localparam logic [1:0] SEL0_A    = 2'b01;
    localparam logic [1:0] SEL0_B    = 2'b10;
    localparam logic [1:0] SEL0_C    = 2'b11;

    // M1: ALU port b
    localparam logic [1:0] SEL1_MUX0 = 2'b00;
    localparam logic [1:0] SEL1_X    = 2'b01;
    localparam logic [1:0] SEL1_S    = 2'b10;
    localparam logic [1:0] SEL1_H    = 2'b11;

    // M2: ALU port a
    localparam logic [1:0] SEL2_X    = 2'b00;
    localparam logic [1:0] SEL2_MUX0 = 2'b01;
    localparam logic [1:0] SEL2_S    = 2'b10;
    localparam logic [1:0] SEL2_H    = 2'b11;

    // ALU operation select, shared with the ALU
    localparam logic ALU_OP_SOMA = 1'b0;
    localparam logic ALU_OP_MULT = 1'b1;

endpackage

// File: rtl/bloco_controle_if.sv
// -----------------------------------------------------------------------------
// bloco_controle_if
// Bundles the controller's system handshake and datapath control signals.
//   inicio   : start request (system -> controller)
//   LX/LS/LH : load strobes for registers X, S, H
//   M0/M1/M2 : operand mux, ALU port b, ALU port a selects
//   H        : ALU operation select
//   ocupado  : busy, high outside OCIOSO
//   pronto   : one-cycle done pulse, S holds the result while high
//   estado   : debug view of the FSM state register
//   contagem : completed-run counter (only with BLOCO_CONTROLE_CONTADOR_EN)
// Modports: master = controller side, slave = system/datapath side.
// Handshake: inicio is a level request sampled only while ocupado=0; a run
// accepted at an edge cannot be cancelled or restarted by inicio, and ends
// with exactly one pronto cycle, after which inicio is sampled again.
// -----------------------------------------------------------------------------
interface bloco_controle_if;
    logic       inicio;
    logic       LX;
    logic       LS;
    logic       LH;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
    logic       H;
    logic       ocupado;
    logic       pronto;
    logic [2:0] estado;
`ifdef BLOCO_CONTROLE_CONTADOR_EN
    logic [7:0] contagem;

    modport master (
        input  inicio,
        output LX, LS, LH, M0, M1, M2, H, ocupado, pronto, estado, contagem
    );
    modport slave (
        output inicio,
        input  LX, LS, LH, M0, M1, M2, H, ocupado, pronto, estado, contagem
    );
`else
    modport master (
        input  inicio,
        output LX, LS, LH, M0, M1, M2, H, ocupado, pronto, estado
    );
    modport slave (
        output inicio,
        input  LX, LS, LH, M0, M1, M2, H, ocupado, pronto, estado
    );
`endif
endinterface

// File: rtl/bloco_controle.sv
// -----------------------------------------------------------------------------
// bloco_controle
// Moore FSM that sequences the operative block through a Horner evaluation
//   resultado = ((A*K)+B)*K + C   (width/truncation handled by the ALU)
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset (forces OCIOSO, all outputs low)
//   bus : bloco_controle_if.master (inicio in; strobes, selects, H, ocupado,
//         pronto, estado debug, optional contagem out)
// Parameters:
//   H_SOMA / H_MULT : value of H selecting ALU addition / multiplication
// Optional feature: define BLOCO_CONTROLE_CONTADOR_EN to add contagem[7:0],
// a saturating count of completed runs.
// -----------------------------------------------------------------------------
module bloco_controle
    import bloco_controle_pkg::*;
#(
    parameter logic H_SOMA = ALU_OP_SOMA,
    parameter logic H_MULT = ALU_OP_MULT
) (
    input logic              clk,
    input logic              rst,
    bloco_controle_if.master bus
);

    estado_t estado_q;
    estado_t estado_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next state and Moore output decode
    always_comb begin
        estado_d    = OCIOSO;
        bus.LX      = 1'b0;
        bus.LS      = 1'b0;
        bus.LH      = 1'b0;
        bus.M0      = SEL0_ZERO;
        bus.M1      = SEL1_MUX0;
        bus.M2      = SEL2_X;
        bus.H       = H_SOMA;
        bus.ocupado = 1'b0;
        bus.pronto  = 1'b0;

        case (estado_q)
            OCIOSO: begin
                estado_d = bus.inicio ? CARGA_X : OCIOSO;
            end
            CARGA_X: begin
                estado_d    = MUL_A;
                bus.ocupado = 1'b1;
                bus.LX      = 1'b1;
            end
            MUL_A: begin
                // S = X * A
                estado_d    = SOMA_B;
                bus.ocupado = 1'b1;
                bus.M2      = SEL2_X;
                bus.M0      = SEL0_A;
                bus.M1      = SEL1_MUX0;
                bus.H       = H_MULT;
                bus.LS      = 1'b1;
            end
            SOMA_B: begin
                // S = S + B
                estado_d    = MUL_X;
                bus.ocupado = 1'b1;
                bus.M2      = SEL2_S;
                bus.M0      = SEL0_B;
                bus.M1      = SEL1_MUX0;
                bus.H       = H_SOMA;
                bus.LS      = 1'b1;
            end
            MUL_X: begin
                // S = S * X
                estado_d    = SOMA_C;
                bus.ocupado = 1'b1;
                bus.M2      = SEL2_S;
                bus.M1      = SEL1_X;
                bus.H       = H_MULT;
                bus.LS      = 1'b1;
            end
            SOMA_C: begin
                // S = S + C
                estado_d    = FIM;
                bus.ocupado = 1'b1;
                bus.M2      = SEL2_S;
                bus.M0      = SEL0_C;
                bus.M1      = SEL1_MUX0;
                bus.H       = H_SOMA;
                bus.LS      = 1'b1;
            end
            FIM: begin
                estado_d    = OCIOSO;
                bus.ocupado = 1'b1;
                bus.pronto  = 1'b1;
            end
            default: begin
                // Unused code: idle outputs, recover to OCIOSO
                estado_d = OCIOSO;
            end
        endcase
    end

    assign bus.estado = estado_q;

`ifdef BLOCO_CONTROLE_CONTADOR_EN
    logic [7:0] contagem_q;
    logic [7:0] contagem_d;

    // FIM always exits on the next edge, so being in FIM marks a completed run
    always_comb begin
        contagem_d = contagem_q;
        if (estado_q == FIM && contagem_q != 8'hFF) begin
            contagem_d = contagem_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem_q <= 8'd0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign bus.contagem = contagem_q;
`endif

endmodule

// File: tb/tb_bloco_controle.sv
// -----------------------------------------------------------------------------
// tb_bloco_controle
// Directed bench for bloco_controle with a small behavioural operative block
// (registers X and S, operand muxes, add/multiply ALU, 16-bit truncation).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_bloco_controle;
    import bloco_controle_pkg::*;

    logic clk;
    logic rst;

    bloco_controle_if bus ();

    bloco_controle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- operative block model ----------------
    logic [15:0] op_a, op_b, op_c, op_k;
    logic [15:0] x_r, s_r, h_r;
    logic [15:0] mux0, alu_a, alu_b, alu_y;

    always_comb begin
        case (bus.M0)
            2'b00:   mux0 = 16'd0;
            2'b01:   mux0 = op_a;
            2'b10:   mux0 = op_b;
            default: mux0 = op_c;
        endcase
        case (bus.M1)
            2'b00:   alu_b = mux0;
            2'b01:   alu_b = x_r;
            2'b10:   alu_b = s_r;
            default: alu_b = h_r;
        endcase
        case (bus.M2)
            2'b00:   alu_a = x_r;
            2'b01:   alu_a = mux0;
            2'b10:   alu_a = s_r;
            default: alu_a = h_r;
        endcase
        alu_y = bus.H ? 16'(alu_a * alu_b) : 16'(alu_a + alu_b);
    end

    // Datapath contents are not affected by the controller reset
    always @(posedge clk) begin
        if (bus.LX) x_r <= op_k;
        if (bus.LS) s_r <= alu_y;
        if (bus.LH) h_r <= alu_y;
    end

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {LX,LS,LH,M0,M1,M2,H,ocupado,pronto}
    function automatic logic [12:0] pack(input logic lx, input logic ls, input logic lh,
                                         input logic [1:0] m0, input logic [1:0] m1,
                                         input logic [1:0] m2, input logic h,
                                         input logic oc, input logic pr);
        return {lx, ls, lh, m0, m1, m2, h, oc, pr};
    endfunction

    function automatic logic [12:0] outs();
        return {bus.LX, bus.LS, bus.LH, bus.M0, bus.M1, bus.M2, bus.H, bus.ocupado, bus.pronto};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_horner(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] k,
                              input logic [15:0] exp, input string tag);
        int n;
        op_a = a; op_b = b; op_c = c; op_k = k;
        bus.inicio = 1'b1;
        step();                       // sampling edge
        bus.inicio = 1'b0;
        n = 0;
        while (bus.pronto !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 5);
        check({tag, "_result"}, s_r, exp);
        step();
        check({tag, "_idle"}, bus.ocupado, 1'b0);
    endtask

    task automatic run_plain();
        bus.inicio = 1'b1;
        step();
        bus.inicio = 1'b0;
        repeat (6) step();
    endtask

    // ---------------- stimulus ----------------
    logic [12:0] exp_tab [7];
    logic [2:0]  st_tab  [7];

    initial begin
        int pulses;
        int first_idx;
        int second_idx;
        int lh_seen;
        int n;

        n_vec = 0; n_err = 0;
        rst = 1'b1;
        bus.inicio = 1'b0;
        op_a = '0; op_b = '0; op_c = '0; op_k = '0;
        x_r = '0; s_r = '0; h_r = '0;

        exp_tab[0] = pack(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0); st_tab[0] = 3'd1; // CARGA_X
        exp_tab[1] = pack(0, 1, 0, 2'b01, 2'b00, 2'b00, 1, 1, 0); st_tab[1] = 3'd2; // MUL_A
        exp_tab[2] = pack(0, 1, 0, 2'b10, 2'b00, 2'b10, 0, 1, 0); st_tab[2] = 3'd3; // SOMA_B
        exp_tab[3] = pack(0, 1, 0, 2'b00, 2'b01, 2'b10, 1, 1, 0); st_tab[3] = 3'd4; // MUL_X
        exp_tab[4] = pack(0, 1, 0, 2'b11, 2'b00, 2'b10, 0, 1, 0); st_tab[4] = 3'd5; // SOMA_C
        exp_tab[5] = pack(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1); st_tab[5] = 3'd6; // FIM
        exp_tab[6] = pack(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0); st_tab[6] = 3'd0; // OCIOSO

        // Reset state
        step(); step();
        check("reset_outs", outs(), 13'd0);
        check("reset_state", bus.estado, 3'd0);
        rst = 1'b0;
        step();
        check("idle_no_start", bus.estado, 3'd0);

        // Per-state table after one inicio pulse
        bus.inicio = 1'b1;
        step();
        bus.inicio = 1'b0;
        lh_seen = 0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("table_outs_%0d", i), outs(), exp_tab[i]);
            check($sformatf("table_state_%0d", i), bus.estado, st_tab[i]);
            if (bus.LH) lh_seen++;
            if (i < 6) step();
        end
        check("lh_never", lh_seen, 0);

        // Integrated Horner runs
        run_horner(16'd2, 16'd3, 16'd4, 16'd5, 16'd69, "h2345");
        run_horner(16'h1000, 16'd0, 16'd1, 16'd16, 16'h0001, "htrunc");
        run_horner(16'd7, 16'd1, 16'd9, 16'd3, 16'd75, "h7193");  // (21+1)*3+9

        // Asynchronous reset during MUL_A
        bus.inicio = 1'b1;
        step();
        bus.inicio = 1'b0;
        step();
        check("pre_rst_state", bus.estado, 3'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outs", outs(), 13'd0);
        check("rst_mid_state", bus.estado, 3'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", bus.estado, 3'd0);
        run_horner(16'd2, 16'd3, 16'd4, 16'd5, 16'd69, "after_rst");

        // inicio held high for 20 sampling edges
        bus.inicio = 1'b1;
        pulses = 0; first_idx = -1; second_idx = -1;
        for (int i = 0; i < 19; i++) begin
            step();
            if (bus.pronto === 1'b1) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
                else if (second_idx < 0) second_idx = i;
            end
        end
        step();                       // 20th sampling edge, third run's FIM
        bus.inicio = 1'b0;
        check("hold_pulses", pulses, 2);
        check("hold_first", first_idx, 5);
        check("hold_gap", second_idx - first_idx, 7);
        n = 0;
        while (bus.ocupado === 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("hold_drain", bus.ocupado, 1'b0);

`ifdef BLOCO_CONTROLE_CONTADOR_EN
        // Completed-run counter
        rst = 1'b1;
        step();
        check("cnt_reset", bus.contagem, 8'd0);
        rst = 1'b0;
        step();
        for (int r = 0; r < 3; r++) run_plain();
        check("cnt_3", bus.contagem, 8'd3);
        for (int r = 0; r < 297; r++) run_plain();
        check("cnt_sat", bus.contagem, 8'd255);
        #2 rst = 1'b1;
        #1;
        check("cnt_clear", bus.contagem, 8'd0);
        step();
        rst = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
